// File: rtl/ttrpg_dice.sv
// Tabletop dice roller: seven dice buttons, two-digit multiplexed 7-segment
// display with PWM dimming, and an HT16K33-style I2C register slave.
module ttrpg_dice #(
   parameter logic [6:0] I2C_ADDR = 7'h70,
   parameter int         MUX_DIV  = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK} i2c_st_t;

   logic w_unused;
   assign w_unused = &{1'b0, ena, ui_in[7], uio_in[4:3], uio_in[0]};

   // Polarity is applied before synchronizing so a polarity flip never
   // produces a phantom press from stale synchronizer contents.
   logic [6:0] w_press_raw, r_btn_s1, r_btn_s2;
   logic       w_any;
   logic [2:0] w_idx;
   logic [3:0] w_max_t, w_max_o, w_nt, w_no;
   logic [3:0] r_cnt_t, r_cnt_o;
   logic [2:0] r_die;
   logic       r_rolling;
   logic [3:0] digit1, digit10;

   assign w_press_raw = ui_in[6:0] ~^ {7{uio_in[5]}};

   always_comb begin
      w_any = |r_btn_s2;
      w_idx = 3'd0;
      for (int i = 6; i >= 0; i--)
         if (r_btn_s2[i]) w_idx = 3'(i);
   end

   // Die maximum in BCD; tens code 10 stands for the hundred of d100.
   always_comb begin
      w_max_t = 4'd0;
      w_max_o = 4'd4;
      case (w_idx)
         3'd1:    w_max_o = 4'd6;
         3'd2:    w_max_o = 4'd8;
         3'd3:    begin w_max_t = 4'd1;  w_max_o = 4'd0; end
         3'd4:    begin w_max_t = 4'd1;  w_max_o = 4'd2; end
         3'd5:    begin w_max_t = 4'd2;  w_max_o = 4'd0; end
         3'd6:    begin w_max_t = 4'd10; w_max_o = 4'd0; end
         default: w_max_o = 4'd4;
      endcase
   end

   always_comb begin
      w_nt = r_cnt_t;
      w_no = r_cnt_o + 4'd1;
      if (!r_rolling || (w_idx != r_die) || (r_cnt_t == w_max_t && r_cnt_o == w_max_o)) begin
         w_nt = 4'd0;
         w_no = 4'd1;
      end else if (r_cnt_o == 4'd9) begin
         w_nt = r_cnt_t + 4'd1;
         w_no = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_s1  <= '0;
         r_btn_s2  <= '0;
         r_rolling <= 1'b0;
         r_cnt_t   <= 4'd0;
         r_cnt_o   <= 4'd0;
         r_die     <= 3'd0;
         digit1    <= 4'hF;
         digit10   <= 4'hF;
      end else begin
         r_btn_s1  <= w_press_raw;
         r_btn_s2  <= r_btn_s1;
         r_rolling <= w_any;
         if (w_any) begin
            r_cnt_t <= w_nt;
            r_cnt_o <= w_no;
            r_die   <= w_idx;
            digit1  <= w_no;
            digit10 <= (w_nt == 4'd0) ? 4'hF : ((w_nt == 4'd10) ? 4'd0 : w_nt);
         end
      end
   end

   // ---------------- display ----------------
   logic [MUX_DIV:0] r_mux;
   logic [6:0]       r_pwm;
   logic [7:0]       r_regs [0:9];
   logic             w_sel, w_on;
   logic [3:0]       w_digit;
   logic [7:0]       w_seg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mux <= '0;
         r_pwm <= 7'd0;
      end else begin
         r_mux <= r_mux + {{MUX_DIV{1'b0}}, 1'b1};
         r_pwm <= r_pwm + 7'd1;
      end
   end

   assign w_sel   = r_mux[MUX_DIV];
   assign w_on    = r_pwm < r_regs[8][6:0];
   assign w_digit = w_sel ? digit10 : digit1;

   always_comb begin
      case (w_digit)
         4'd0:    w_seg = 8'h3F;
         4'd1:    w_seg = 8'h06;
         4'd2:    w_seg = 8'h5B;
         4'd3:    w_seg = 8'h4F;
         4'd4:    w_seg = 8'h66;
         4'd5:    w_seg = 8'h6D;
         4'd6:    w_seg = 8'h7D;
         4'd7:    w_seg = 8'h07;
         4'd8:    w_seg = 8'h7F;
         4'd9:    w_seg = 8'h6F;
         default: w_seg = 8'h00;
      endcase
   end

   logic r_sda_oe;
   assign uo_out  = (w_on ? w_seg : 8'h00) ^ {8{~uio_in[6]}};
   assign uio_out = {3'b000,
                     (w_on &&  w_sel) ? uio_in[7] : ~uio_in[7],
                     (w_on && !w_sel) ? uio_in[7] : ~uio_in[7],
                     3'b000};
   assign uio_oe  = {3'b000, 2'b11, 1'b0, r_sda_oe, 1'b0};

   // ---------------- I2C slave ----------------
   logic r_sda_s1, r_sda_s2, r_sda_d, r_scl_s1, r_scl_s2, r_scl_d;
   logic w_start, w_stop, w_rise, w_fall;
   i2c_st_t r_state, w_nstate;
   logic [3:0] r_bit, r_ptr;
   logic [7:0] r_shift, w_rdata;
   logic       r_first;
   logic       w_oe_nxt, w_shin, w_bitinc, w_bit_clr, w_load, w_shout, w_commit, w_first_set;

   assign w_start = r_scl_d &  r_scl_s2 &  r_sda_d & ~r_sda_s2;
   assign w_stop  = r_scl_d &  r_scl_s2 & ~r_sda_d &  r_sda_s2;
   assign w_rise  = ~r_scl_d &  r_scl_s2;
   assign w_fall  =  r_scl_d & ~r_scl_s2;

   always_comb begin
      w_rdata = 8'h00;
      if (r_ptr < 4'd10)
         w_rdata = r_regs[r_ptr];
      else if (r_ptr == 4'd10)
         w_rdata = {(digit10 == 4'hF) ? 4'd0 : digit10, (digit1 == 4'hF) ? 4'd0 : digit1};
      else if (r_ptr == 4'd11)
         w_rdata = {5'b0, r_die};
   end

   always_comb begin
      w_nstate    = r_state;
      w_oe_nxt    = r_sda_oe;
      w_shin      = 1'b0;
      w_bitinc    = 1'b0;
      w_bit_clr   = 1'b0;
      w_load      = 1'b0;
      w_shout     = 1'b0;
      w_commit    = 1'b0;
      w_first_set = 1'b0;
      if (w_start) begin
         w_nstate  = S_ADDR;
         w_oe_nxt  = 1'b0;
         w_bit_clr = 1'b1;
      end else if (w_stop) begin
         w_nstate = S_IDLE;
         w_oe_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ADDR:
               if (w_rise) w_shin = 1'b1;
               else if (w_fall && r_bit == 4'd8) begin
                  if (r_shift[7:1] == I2C_ADDR) begin
                     w_nstate = S_AACK;
                     w_oe_nxt = 1'b1;
                  end else
                     w_nstate = S_IDLE;
               end
            S_AACK:
               if (w_fall) begin
                  w_bit_clr = 1'b1;
                  if (r_shift[0]) begin
                     w_nstate = S_RD;
                     w_load   = 1'b1;
                     w_oe_nxt = ~w_rdata[7];
                  end else begin
                     w_nstate    = S_WR;
                     w_first_set = 1'b1;
                     w_oe_nxt    = 1'b0;
                  end
               end
            S_WR:
               if (w_rise) w_shin = 1'b1;
               else if (w_fall && r_bit == 4'd8) begin
                  w_nstate = S_WACK;
                  w_oe_nxt = 1'b1;
                  w_commit = 1'b1;
               end
            S_WACK:
               if (w_fall) begin
                  w_nstate  = S_WR;
                  w_oe_nxt  = 1'b0;
                  w_bit_clr = 1'b1;
               end
            S_RD:
               if (w_rise) w_bitinc = 1'b1;
               else if (w_fall) begin
                  if (r_bit == 4'd8) begin
                     w_nstate  = S_RACK;
                     w_oe_nxt  = 1'b0;
                     w_bit_clr = 1'b1;
                  end else begin
                     w_shout  = 1'b1;
                     w_oe_nxt = ~r_shift[6];
                  end
               end
            S_RACK:
               // master's ACK/NAK lands in r_shift[0] on the rising edge
               if (w_rise) w_shin = 1'b1;
               else if (w_fall) begin
                  if (!r_shift[0]) begin
                     w_nstate = S_RD;
                     w_load   = 1'b1;
                     w_oe_nxt = ~w_rdata[7];
                  end else begin
                     w_nstate = S_IDLE;
                     w_oe_nxt = 1'b0;
                  end
               end
            default: w_nstate = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_d  <= 1'b1;
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_d  <= 1'b1;
         r_state  <= S_IDLE;
         r_sda_oe <= 1'b0;
         r_bit    <= 4'd0;
         r_shift  <= 8'h00;
         r_ptr    <= 4'd0;
         r_first  <= 1'b0;
         for (int i = 0; i < 10; i++)
            r_regs[i] <= (i == 8) ? 8'h7F : 8'h00;
      end else begin
         r_sda_s1 <= uio_in[1];
         r_sda_s2 <= r_sda_s1;
         r_sda_d  <= r_sda_s2;
         r_scl_s1 <= uio_in[2];
         r_scl_s2 <= r_scl_s1;
         r_scl_d  <= r_scl_s2;
         r_state  <= w_nstate;
         r_sda_oe <= w_oe_nxt;
         if (w_bit_clr || w_load)    r_bit <= 4'd0;
         else if (w_shin || w_bitinc) r_bit <= r_bit + 4'd1;
         if (w_shin)       r_shift <= {r_shift[6:0], r_sda_s2};
         else if (w_load)  r_shift <= w_rdata;
         else if (w_shout) r_shift <= {r_shift[6:0], 1'b0};
         if (w_load) r_ptr <= r_ptr + 4'd1;
         if (w_first_set) r_first <= 1'b1;
         if (w_commit) begin
            if (r_first) begin
               r_ptr   <= r_shift[3:0];
               r_first <= 1'b0;
            end else begin
               if (r_ptr < 4'd10) r_regs[r_ptr] <= r_shift;
               r_ptr <= r_ptr + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ttrpg_dice.sv
// Directed bench for ttrpg_dice: rolls, display mux/polarity, I2C register
// access, PWM duty and asynchronous reset in mid-operation.
module tb_ttrpg_dice;

   localparam int Q = 8;
   localparam logic [7:0] WSUB [5] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08};
   localparam logic [7:0] WD0  [5] = '{8'hAA, 8'h69, 8'h01, 8'h03, 8'h2B};
   localparam logic [7:0] WD1  [5] = '{8'h55, 8'h96, 8'h02, 8'h04, 8'hFF};
   localparam logic [7:0] RD_EXP [12] = '{8'hAA, 8'h55, 8'h69, 8'h96, 8'h01, 8'h02,
                                          8'h03, 8'h04, 8'h2B, 8'hFF, 8'h57, 8'h06};
   localparam logic [7:0] RST_EXP [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                           8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00};
   localparam logic [7:0] PWM_V [4] = '{8'h21, 8'h41, 8'h01, 8'h7F};
   localparam int DIE_N [7] = '{4, 6, 8, 10, 12, 20, 100};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [2:0] cfg = 3'b111;
   logic       m_sda = 1'b1, m_scl = 1'b1;
   wire  [7:0] uo_out, uio_out, uio_oe;
   wire        sda_line = m_sda & ~uio_oe[1];
   wire  [7:0] uio_in = {cfg, 2'b00, m_scl, sda_line, 1'b0};
   logic [7:0] rbuf [12];
   int checks = 0, errors = 0;

   ttrpg_dice #(.I2C_ADDR(7'h70), .MUX_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] seg(input int d);
      case (d)
         0: seg = 8'h3F; 1: seg = 8'h06; 2: seg = 8'h5B; 3: seg = 8'h4F; 4: seg = 8'h66;
         5: seg = 8'h6D; 6: seg = 8'h7D; 7: seg = 8'h07; 8: seg = 8'h7F; 9: seg = 8'h6F;
         default: seg = 8'h00;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic roll(input int die, input int hold);
      logic [7:0] idle;
      idle  = cfg[0] ? 8'h00 : 8'hFF;
      @(negedge clk);
      ui_in = idle ^ (8'h01 << die);
      tick(hold);
      ui_in = idle;
      tick(5);
   endtask

   task automatic wait_com(input int idx, input logic lvl, output bit found);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (uio_out[idx] === lvl) found = 1'b1;
      end
   endtask

   task automatic i2c_start;
      m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop;
      m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
   endtask

   task automatic i2c_wbyte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         m_sda = b[i]; tick(Q); m_scl = 1'b1; tick(Q); m_scl = 1'b0; tick(Q);
      end
      m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
      ack = ~sda_line;
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_rbyte(input logic nak, output logic [7:0] b);
      m_sda = 1'b1;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick(Q); m_scl = 1'b1; tick(Q);
         b = {b[6:0], sda_line};
         m_scl = 1'b0;
      end
      m_sda = nak; tick(Q); m_scl = 1'b1; tick(Q); m_scl = 1'b0; tick(Q);
      m_sda = 1'b1;
   endtask

   task automatic i2c_write(input logic [7:0] ab, input logic [7:0] sub, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, output logic [3:0] acks);
      logic a;
      acks = 4'h0;
      i2c_start;
      i2c_wbyte(ab, a);  acks[0] = a;
      i2c_wbyte(sub, a); acks[1] = a;
      i2c_wbyte(d0, a);  acks[2] = a;
      if (n > 1) begin i2c_wbyte(d1, a); acks[3] = a; end
      i2c_stop;
   endtask

   task automatic i2c_read(input logic [7:0] sub, input int n, output logic [2:0] acks);
      logic a;
      logic [7:0] b;
      acks = 3'h0;
      i2c_start;
      i2c_wbyte(8'hE0, a); acks[0] = a;
      i2c_wbyte(sub, a);   acks[1] = a;
      i2c_start;
      i2c_wbyte(8'hE1, a); acks[2] = a;
      for (int k = 0; k < n; k++) begin
         i2c_rbyte(k == n - 1, b);
         rbuf[k] = b;
      end
      i2c_stop;
   endtask

   task automatic test_reset;
      tick(4);
      checks++;
      if (dut.digit1 !== 4'hF || dut.digit10 !== 4'hF) begin
         errors++; $display("FAIL reset_digits: got %h/%h expected f/f", dut.digit10, dut.digit1);
      end
      checks++;
      if (uio_oe !== 8'h18 || uio_out[1] !== 1'b0) begin
         errors++; $display("FAIL reset_oe: got oe=%h out=%h expected oe=18 sda_out=0", uio_oe, uio_out);
      end
      rst_n = 1'b1;
      tick(3);
      checks++;
      if (uo_out !== 8'h00) begin
         errors++; $display("FAIL reset_blank: got %h expected 00", uo_out);
      end
   endtask

   task automatic test_roll_d6;
      int holds [3] = '{6, 13, 9};
      int v;
      bit f;
      cfg = 3'b111;
      ui_in = 8'h00;
      foreach (holds[k]) begin
         roll(1, holds[k]);
         v = ((holds[k] - 1) % DIE_N[1]) + 1;
         checks++;
         if (dut.digit1 !== 4'(v) || dut.digit10 !== 4'hF) begin
            errors++;
            $display("FAIL d6_hold%0d: got %h/%h expected f/%0d", holds[k], dut.digit10, dut.digit1, v);
         end
      end
      wait_com(3, 1'b1, f);
      checks++;
      if (!f || uo_out !== seg(3)) begin
         errors++; $display("FAIL d6_disp_ones: got %h (slot seen %0d) expected %h", uo_out, f, seg(3));
      end
      wait_com(4, 1'b1, f);
      checks++;
      if (!f || uo_out !== 8'h00) begin
         errors++; $display("FAIL d6_disp_tens: got %h (slot seen %0d) expected 00", uo_out, f);
      end
   endtask

   task automatic test_roll_d100;
      int holds [3] = '{100, 205, 57};
      int v, e1, e10;
      bit f;
      cfg = 3'b000;
      ui_in = 8'hFF;
      tick(4);
      foreach (holds[k]) begin
         roll(6, holds[k]);
         v   = ((holds[k] - 1) % DIE_N[6]) + 1;
         e1  = v % 10;
         e10 = (v < 10) ? 15 : (v / 10) % 10;
         checks++;
         if (dut.digit1 !== 4'(e1) || dut.digit10 !== 4'(e10)) begin
            errors++;
            $display("FAIL d100_hold%0d: got %h/%h expected %h/%h", holds[k], dut.digit10, dut.digit1, e10, e1);
         end
         if (k != 1) begin
            wait_com(3, 1'b0, f);
            checks++;
            if (!f || uo_out !== ~seg(e1)) begin
               errors++; $display("FAIL d100_disp_ones%0d: got %h expected %h", v, uo_out, ~seg(e1));
            end
            wait_com(4, 1'b0, f);
            checks++;
            if (!f || uo_out !== ~seg(e10)) begin
               errors++; $display("FAIL d100_disp_tens%0d: got %h expected %h", v, uo_out, ~seg(e10));
            end
         end
      end
   endtask

   task automatic test_i2c_regs;
      logic [3:0] acks;
      logic [2:0] racks;
      for (int k = 0; k < 5; k++) begin
         i2c_write(8'hE0, WSUB[k], 2, WD0[k], WD1[k], acks);
         checks++;
         if (acks !== 4'hF) begin
            errors++; $display("FAIL wr_ack_sub%0d: got %b expected 1111", WSUB[k], acks);
         end
      end
      i2c_read(8'h00, 12, racks);
      checks++;
      if (racks !== 3'h7) begin
         errors++; $display("FAIL rd_ack: got %b expected 111", racks);
      end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (rbuf[k] !== RD_EXP[k]) begin
            errors++; $display("FAIL rd_reg%0d: got %h expected %h", k, rbuf[k], RD_EXP[k]);
         end
      end
      checks++;
      if (uio_oe[1] !== 1'b0) begin
         errors++; $display("FAIL sda_released: got %b expected 0", uio_oe[1]);
      end
   endtask

   task automatic test_ptr_high;
      logic [3:0] acks;
      logic [2:0] racks;
      i2c_write(8'hE0, 8'h0C, 1, 8'h5A, 8'h00, acks);
      checks++;
      if (acks !== 4'h7) begin
         errors++; $display("FAIL wr12_ack: got %b expected 0111", acks);
      end
      i2c_read(8'h0C, 5, racks);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (rbuf[k] !== ((k == 4) ? 8'hAA : 8'h00)) begin
            errors++; $display("FAIL rd_hi%0d: got %h expected %h", k, rbuf[k], (k == 4) ? 8'hAA : 8'h00);
         end
      end
   endtask

   task automatic test_addr_nak;
      logic [3:0] acks;
      logic [2:0] racks;
      i2c_write(8'hE2, 8'h00, 2, 8'h11, 8'h22, acks);
      checks++;
      if (acks !== 4'h0) begin
         errors++; $display("FAIL nak_addr71: got %b expected 0000", acks);
      end
      i2c_read(8'h00, 2, racks);
      checks++;
      if (racks !== 3'h7 || rbuf[0] !== 8'hAA || rbuf[1] !== 8'h55) begin
         errors++; $display("FAIL nak_nochange: got %h %h acks %b expected aa 55 acks 111", rbuf[0], rbuf[1], racks);
      end
   endtask

   task automatic test_pwm;
      logic [3:0] acks;
      int cnt, exp_on;
      for (int k = 0; k < 4; k++) begin
         i2c_write(8'hE0, 8'h08, 1, PWM_V[k], 8'h00, acks);
         exp_on = int'(PWM_V[k]) & 127;
         cnt = 0;
         tick(4);
         for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            if (uio_out[3] === cfg[2] || uio_out[4] === cfg[2]) cnt++;
         end
         checks++;
         if (acks !== 4'h7 || cnt != exp_on) begin
            errors++; $display("FAIL pwm_%h: got %0d/128 ack %b expected %0d/128", PWM_V[k], cnt, acks, exp_on);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [2:0] racks;
      logic [7:0] ab;
      ab = 8'hE0;
      cfg = 3'b000;
      ui_in = ~8'h20;
      i2c_start;
      for (int i = 7; i >= 0; i--) begin
         m_sda = ab[i]; tick(Q); m_scl = 1'b1; tick(Q); m_scl = 1'b0; tick(Q);
      end
      m_sda = 1'b1; tick(Q);
      checks++;
      if (uio_oe[1] !== 1'b1) begin
         errors++; $display("FAIL mid_ack_driven: got %b expected 1", uio_oe[1]);
      end
      rst_n = 1'b0;
      tick(2);
      checks++;
      if (uio_oe[1] !== 1'b0 || dut.digit1 !== 4'hF || dut.digit10 !== 4'hF || uo_out !== 8'hFF) begin
         errors++;
         $display("FAIL mid_reset: got oe1=%b digits=%h/%h seg=%h expected 0 f/f ff",
                  uio_oe[1], dut.digit10, dut.digit1, uo_out);
      end
      ui_in = 8'hFF;
      m_scl = 1'b1;
      m_sda = 1'b1;
      tick(4);
      rst_n = 1'b1;
      tick(4);
      i2c_read(8'h00, 12, racks);
      checks++;
      if (racks !== 3'h7) begin
         errors++; $display("FAIL post_rst_ack: got %b expected 111", racks);
      end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (rbuf[k] !== RST_EXP[k]) begin
            errors++; $display("FAIL post_rst_reg%0d: got %h expected %h", k, rbuf[k], RST_EXP[k]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_roll_d6;
      test_roll_d100;
      test_i2c_regs;
      test_ptr_high;
      test_addr_nak;
      test_pwm;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
